alu_acc_seq: RTL

Parametrised accumulator ALU for the BitCruncher datapath, and the successor to the fixed 16-bit, one-hot-controlled ALU/ACC. The CU issues a binary-encoded opcode through a valid/ready handshake. Logic, add, sub and shift ops complete in one cycle. MUL and DIV are iterative and take DATA_W cycles, with the high product word or remainder held in a second register. The block reports ZF/CF/OF/SF flags, a done pulse and a sticky divide-by-zero status.

---
 rtl/alu_acc_seq_if.sv | 28 ++
 rtl/alu_acc_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_acc_seq_if.sv
// Operation/result bus between the control unit and the accumulator ALU.
// The control unit is the master: it presents an opcode and BR operand
// under a valid/ready handshake and observes the accumulator, flags and
// status outputs.
interface alu_acc_seq_if #(
    parameter int DATA_W = 16
);
    logic              op_valid;
    logic              op_ready;
    logic [3:0]        op_code;
    logic [DATA_W-1:0] br_in;
    logic [DATA_W-1:0] acc_out;
    logic [DATA_W-1:0] acc_hi_out;
    logic [3:0]        flags;        // {ZF, CF, OF, SF}
    logic              busy;
    logic              done;
    logic              div_by_zero;

    modport master (
        output op_valid, op_code, br_in,
        input  op_ready, acc_out, acc_hi_out, flags, busy, done, div_by_zero
    );

    modport slave (
        input  op_valid, op_code, br_in,
        output op_ready, acc_out, acc_hi_out, flags, busy, done, div_by_zero
    );
endinterface

// File: rtl/alu_acc_seq.sv
// Parametrised accumulator ALU. Logic, add, sub and shift ops retire at the
// acceptance edge; MUL (shift-add) and DIV (restoring) iterate for DATA_W
// cycles in private working registers so the architectural accumulator
// holds its old value until writeback. DATA_W must be a power of two >= 4.
module alu_acc_seq #(
    parameter int DATA_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_acc_seq_if.slave bus
);
    localparam int SH_W = $clog2(DATA_W);

    typedef enum logic [3:0] {
        OP_CLR = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_MUL = 4'd3,
        OP_DIV = 4'd4,
        OP_SHL = 4'd5,
        OP_SHR = 4'd6,
        OP_AND = 4'd7,
        OP_OR  = 4'd8,
        OP_NOT = 4'd9
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [SH_W-1:0]   cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic [DATA_W-1:0] br_q, br_d;
    logic [DATA_W-1:0] work_hi_q, work_hi_d;   // partial product high / remainder
    logic [DATA_W-1:0] work_lo_q, work_lo_d;   // multiplier bits / quotient bits
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] acc_hi_q, acc_hi_d;
    logic [3:0]        flags_q, flags_d;
    logic              done_q, done_d;
    logic              dbz_q, dbz_d;

    // Flag word from an accumulator result plus op-specific carry/overflow.
    function automatic logic [3:0] mk_flags(input logic [DATA_W-1:0] res,
                                            input logic cf, input logic of);
        return {res == '0, cf, of, res[DATA_W-1]};
    endfunction

    // Single-cycle datapath, driven from the live operand at acceptance.
    logic [SH_W-1:0] sh_amt;
    logic [DATA_W:0] add_sum;
    logic [DATA_W:0] sub_diff;
    logic [DATA_W:0] shl_ext;    // {carry_out, result}
    logic [DATA_W:0] shr_ext;    // {result, carry_out}
    logic            add_of;
    logic            sub_of;

    assign sh_amt   = bus.br_in[SH_W-1:0];
    assign add_sum  = {1'b0, acc_q} + {1'b0, bus.br_in};
    assign sub_diff = {1'b0, acc_q} - {1'b0, bus.br_in};   // MSB is the borrow
    assign shl_ext  = {1'b0, acc_q} << sh_amt;
    assign shr_ext  = {acc_q, 1'b0} >> sh_amt;
    assign add_of   = (acc_q[DATA_W-1] == bus.br_in[DATA_W-1]) &&
                      (add_sum[DATA_W-1] != acc_q[DATA_W-1]);
    assign sub_of   = (acc_q[DATA_W-1] != bus.br_in[DATA_W-1]) &&
                      (sub_diff[DATA_W-1] != acc_q[DATA_W-1]);

    // One iteration of the multi-cycle datapath, driven from the latched operand.
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W-1:0] mul_hi;
    logic [DATA_W-1:0] mul_lo;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W:0]   div_sub;
    logic              div_fits;
    logic [DATA_W-1:0] div_rem;
    logic [DATA_W-1:0] div_quo;

    assign mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, br_q} : '0);
    assign mul_hi    = mul_sum[DATA_W:1];
    assign mul_lo    = {mul_sum[0], work_lo_q[DATA_W-1:1]};
    assign div_shift = {work_hi_q, work_lo_q[DATA_W-1]};
    assign div_sub   = div_shift - {1'b0, br_q};
    assign div_fits  = div_shift >= {1'b0, br_q};
    assign div_rem   = div_fits ? div_sub[DATA_W-1:0] : div_shift[DATA_W-1:0];
    assign div_quo   = {work_lo_q[DATA_W-2:0], div_fits};

    // Next-state logic: op acceptance and decode in IDLE, iteration and writeback in RUN.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        br_d      = br_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        acc_d     = acc_q;
        acc_hi_d  = acc_hi_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.op_valid) begin
                    done_d = 1'b1;
                    dbz_d  = 1'b0;
                    case (bus.op_code)
                        OP_CLR: begin
                            acc_d    = '0;
                            acc_hi_d = '0;
                            flags_d  = mk_flags('0, 1'b0, 1'b0);
                        end
                        OP_ADD: begin
                            acc_d   = add_sum[DATA_W-1:0];
                            flags_d = mk_flags(add_sum[DATA_W-1:0], add_sum[DATA_W], add_of);
                        end
                        OP_SUB: begin
                            acc_d   = sub_diff[DATA_W-1:0];
                            flags_d = mk_flags(sub_diff[DATA_W-1:0], sub_diff[DATA_W], sub_of);
                        end
                        OP_SHL: begin
                            acc_d   = shl_ext[DATA_W-1:0];
                            flags_d = mk_flags(shl_ext[DATA_W-1:0], shl_ext[DATA_W], 1'b0);
                        end
                        OP_SHR: begin
                            acc_d   = shr_ext[DATA_W:1];
                            flags_d = mk_flags(shr_ext[DATA_W:1], shr_ext[0], 1'b0);
                        end
                        OP_AND: begin
                            acc_d   = acc_q & bus.br_in;
                            flags_d = mk_flags(acc_q & bus.br_in, 1'b0, 1'b0);
                        end
                        OP_OR: begin
                            acc_d   = acc_q | bus.br_in;
                            flags_d = mk_flags(acc_q | bus.br_in, 1'b0, 1'b0);
                        end
                        OP_NOT: begin
                            acc_d   = ~bus.br_in;
                            flags_d = mk_flags(~bus.br_in, 1'b0, 1'b0);
                        end
                        OP_MUL: begin
                            done_d    = 1'b0;
                            state_d   = ST_RUN;
                            cnt_d     = SH_W'(DATA_W - 1);
                            is_div_d  = 1'b0;
                            br_d      = bus.br_in;
                            work_hi_d = '0;
                            work_lo_d = acc_q;
                        end
                        OP_DIV: begin
                            if (bus.br_in == '0) begin
                                // Divide by zero retires immediately with a saturated quotient.
                                acc_d    = '1;
                                acc_hi_d = acc_q;
                                flags_d  = mk_flags('1, 1'b0, 1'b1);
                                dbz_d    = 1'b1;
                            end else begin
                                done_d    = 1'b0;
                                state_d   = ST_RUN;
                                cnt_d     = SH_W'(DATA_W - 1);
                                is_div_d  = 1'b1;
                                br_d      = bus.br_in;
                                work_hi_d = '0;
                                work_lo_d = acc_q;
                            end
                        end
                        default: ;   // NOP: only done and the sticky clear
                    endcase
                end
            end

            ST_RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (is_div_q) begin
                    work_hi_d = div_rem;
                    work_lo_d = div_quo;
                end else begin
                    work_hi_d = mul_hi;
                    work_lo_d = mul_lo;
                end
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (is_div_q) begin
                        acc_d    = div_quo;
                        acc_hi_d = div_rem;
                        flags_d  = mk_flags(div_quo, 1'b0, 1'b0);
                    end else begin
                        acc_d    = mul_lo;
                        acc_hi_d = mul_hi;
                        flags_d  = mk_flags(mul_lo, |mul_hi, |mul_hi);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            br_q      <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            acc_q     <= '0;
            acc_hi_q  <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            br_q      <= br_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            acc_q     <= acc_d;
            acc_hi_q  <= acc_hi_d;
            flags_q   <= flags_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign bus.op_ready    = (state_q == ST_IDLE);
    assign bus.busy        = (state_q == ST_RUN);
    assign bus.acc_out     = acc_q;
    assign bus.acc_hi_out  = acc_hi_q;
    assign bus.flags       = flags_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
endmodule
